axis_sync_fifo: RTL and testbench

- Single-clock AXI-Stream FIFO.
- Decouples an upstream AXIS master from a downstream AXIS slave. Absorbs backpressure bursts and carries every sideband field (tdata, tkeep, tlast, tuser, tid, tdest).
- Sits directly upstream or downstream of any AXIS stage in the datapath; its s_axis_* and m_axis_* ports map one-to-one onto the slave and master views of the AXIS interface.

---
 rtl/axis_sync_fifo_pkg.sv | 14 +
 rtl/axis_sync_fifo_if.sv | 31 +++
 rtl/axis_sync_fifo_mem.sv | 22 ++
 rtl/axis_sync_fifo.sv | 114 +++++++++++
 tb/tb_axis_sync_fifo.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sync_fifo_pkg.sv
// Shared AXIS defaults and pointer-width helper for the synchronous AXIS FIFO.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_USER_W = 1;
  localparam int unsigned AXIS_ID_W   = 1;
  localparam int unsigned AXIS_DEST_W = 1;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int unsigned axis_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream bundle with master (source) and slave (sink) views.
interface axis_sync_fifo_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_W,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = AXIS_USER_W,
  parameter int unsigned ID_WIDTH   = AXIS_ID_W,
  parameter int unsigned DEST_WIDTH = AXIS_DEST_W
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tid, tdest, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tid, tdest, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_sync_fifo_mem.sv
// Register array: one synchronous write port, one asynchronous read port.
module axis_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO.
// Define AXIS_SYNC_FIFO_FRAME_EN for store-and-forward (whole-frame) release.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_W,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = AXIS_USER_W,
  parameter int unsigned ID_WIDTH   = AXIS_ID_W,
  parameter int unsigned DEST_WIDTH = AXIS_DEST_W,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axis_sync_fifo_if.slave                s_axis,
  axis_sync_fifo_if.master               m_axis,
  output logic [axis_ptr_w(DEPTH)-1:0]   count,
  output logic                           overflow
);

  localparam int unsigned PW = axis_ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
  } beat_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  beat_t         wbeat;
  beat_t         rbeat;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // tready depends on registered pointers and reset only, never on m_axis.tready.
  assign s_axis.tready = rst && !full;

  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = m_axis.tvalid && m_axis.tready;

  always_comb begin
    wbeat       = '0;
    wbeat.tdata = s_axis.tdata;
    wbeat.tkeep = s_axis.tkeep;
    wbeat.tlast = s_axis.tlast;
    wbeat.tuser = s_axis.tuser;
    wbeat.tid   = s_axis.tid;
    wbeat.tdest = s_axis.tdest;
  end

  axis_fifo_mem #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wbeat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rbeat)
  );

  assign m_axis.tdata = rbeat.tdata;
  assign m_axis.tkeep = rbeat.tkeep;
  assign m_axis.tlast = rbeat.tlast;
  assign m_axis.tuser = rbeat.tuser;
  assign m_axis.tid   = rbeat.tid;
  assign m_axis.tdest = rbeat.tdest;

`ifdef AXIS_SYNC_FIFO_FRAME_EN
  logic [PW-1:0] frames;

  // Release only complete frames; the full term lets over-long frames cut through.
  assign m_axis.tvalid = !empty && ((frames != '0) || full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames <= '0;
    end else begin
      unique case ({wr_en && s_axis.tlast, rd_en && m_axis.tlast})
        2'b10:   frames <= frames + PW'(1);
        2'b01:   frames <= frames - PW'(1);
        default: frames <= frames;
      endcase
    end
  end
`else
  assign m_axis.tvalid = !empty;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)                 wr_ptr   <= wr_ptr + PW'(1);
      if (rd_en)                 rd_ptr   <= rd_ptr + PW'(1);
      if (s_axis.tvalid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed self-checking bench for axis_sync_fifo (DEPTH=16, 32-bit data).
module tb_axis_sync_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = 4;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
    logic          id;
    logic          dest;
  } tb_beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] count;
  logic       overflow;

  axis_sync_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .ID_WIDTH(1), .DEST_WIDTH(1)) s_if ();
  axis_sync_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .ID_WIDTH(1), .DEST_WIDTH(1)) m_if ();

  axis_sync_fifo #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .USER_WIDTH (1),
    .ID_WIDTH   (1),
    .DEST_WIDTH (1),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rx_cnt   = 0;
  bit          mon_en   = 1'b0;
  bit          prev_stall = 1'b0;
  tb_beat_t    prev_beat;
  tb_beat_t    sb[$];
  tb_beat_t    mbeat;
  tb_beat_t    sbeat;

  assign mbeat = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, m_if.tid, m_if.tdest};
  assign sbeat = {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser, s_if.tid, s_if.tdest};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and stall-stability monitor; sampled mid-cycle, handshakes commit on the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_eq("stall_valid", 64'(m_if.tvalid), 64'd1);
        check_eq("stall_hold", 64'(mbeat), 64'(prev_beat));
      end
      if (m_if.tvalid && m_if.tready) begin
        check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check_eq("sb_beat", 64'(mbeat), 64'(sb.pop_front()));
        rx_cnt++;
      end
      if (s_if.tvalid && s_if.tready) sb.push_back(sbeat);
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = mbeat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic tb_beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l,
                                  input logic u, input logic id, input logic dest);
    tb_beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u; b.id = id; b.dest = dest;
    return b;
  endfunction

  task automatic drive(input tb_beat_t b);
    s_if.tdata = b.d; s_if.tkeep = b.k; s_if.tlast = b.l;
    s_if.tuser = b.u; s_if.tid = b.id; s_if.tdest = b.dest;
  endtask

  // Present one beat and hold it until accepted; returns cycles taken.
  task automatic send(input tb_beat_t b, output int unsigned cycles);
    bit acc;
    cycles = 0;
    drive(b);
    s_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk); #1;
      cycles++;
    end while (!acc && cycles < 200);
    if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    m_if.tready = 1'b1;
    while ((m_if.tvalid || count != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", 64'(count), 64'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned rx0;
    int unsigned sent;
    int unsigned guard;
    bit          acc;
    tb_beat_t    b;

    s_if.tvalid = 1'b0;
    drive('0);
    m_if.tready = 1'b0;

    // Reset state
    #2;
    check_eq("rst_tready", 64'(s_if.tready), 64'd0);
    check_eq("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check_eq("idle_tready", 64'(s_if.tready), 64'd1);

    // Fill with 17 beats, 16 fit
    for (int i = 0; i < 16; i++) begin
      send(mk(32'(i), 4'hF, 1'b1, 1'b0, 1'b0, 1'b0), cyc);
      if (i == 0) begin
        check_eq("fwft_tvalid", 64'(m_if.tvalid), 64'd1);
        check_eq("fwft_count", 64'(count), 64'd1);
        check_eq("fwft_data", 64'(m_if.tdata), 64'd0);
      end
    end
    check_eq("full_count", 64'(count), 64'd16);
    check_eq("full_tready", 64'(s_if.tready), 64'd0);
    check_eq("full_no_ovf", 64'(overflow), 64'd0);
    drive(mk(32'd16, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0));
    s_if.tvalid = 1'b1;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    check_eq("ovf_set", 64'(overflow), 64'd1);
    check_eq("ovf_count", 64'(count), 64'd16);
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("fill_rd_valid", 64'(m_if.tvalid), 64'd1);
      check_eq("fill_rd_data", 64'(m_if.tdata), 64'(i));
      @(posedge clk); #1;
    end
    check_eq("fill_beat16_dropped", 64'(m_if.tvalid), 64'd0);
    m_if.tready = 1'b0;

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) send(mk(32'(100 + i), 4'h3, 1'b1, 1'b1, 1'b0, 1'b1), cyc);
    rx0 = rx_cnt;
    drive(mk(32'd200, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0));
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    @(negedge clk);
    check_eq("fr_tready_low", 64'(s_if.tready), 64'd0);
    @(posedge clk); #1;
    check_eq("fr_count15", 64'(count), 64'd15);
    check_eq("fr_tready_back", 64'(s_if.tready), 64'd1);
    m_if.tready = 1'b0;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    check_eq("fr_count16", 64'(count), 64'd16);
    drain();
    check_eq("fr_rx", 64'(rx_cnt - rx0), 64'd17);

    // Streaming 100 beats back to back
    rx0 = rx_cnt;
    m_if.tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b = mk(32'(i), 4'(i), 1'b1, 1'(i), 1'(i >> 1), 1'(i >> 2));
      send(b, cyc);
      check_eq("stream_1cyc", 64'(cyc), 64'd1);
      check_eq("stream_count", 64'(count), 64'd1);
    end
    drain();
    check_eq("stream_rx", 64'(rx_cnt - rx0), 64'd100);

    // Random backpressure, 1000 beats
    rx0 = rx_cnt;
    sent = 0;
    guard = 0;
    b = mk($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(b);
    s_if.tvalid = 1'b1;
    while (sent < 1000 && guard < 20000) begin
      m_if.tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s_if.tvalid && s_if.tready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        b = mk($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        if (sent == 999) b.l = 1'b1;
        drive(b);
        s_if.tvalid = (sent < 1000);
      end
    end
    s_if.tvalid = 1'b0;
    check_eq("bp_sent", 64'(sent), 64'd1000);
    drain();
    check_eq("bp_rx", 64'(rx_cnt - rx0), 64'd1000);

    // Asynchronous reset mid-frame
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) send(mk(32'(300 + i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0), cyc);
    check_eq("mid_count5", 64'(count), 64'd5);
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("mid_tvalid", 64'(m_if.tvalid), 64'd0);
    check_eq("mid_count", 64'(count), 64'd0);
    check_eq("mid_overflow", 64'(overflow), 64'd0);
    check_eq("mid_tready", 64'(s_if.tready), 64'd0);
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 3; i++) send(mk(32'(400 + i), 4'hA, 1'(i == 2), 1'b1, 1'b1, 1'b1), cyc);
    check_eq("post_count", 64'(count), 64'd3);
    drain();
    check_eq("post_rx", 64'(rx_cnt - rx0), 64'd3);

`ifdef AXIS_SYNC_FIFO_FRAME_EN
    // Store-and-forward: short frame held until tlast is in
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(mk(32'(500 + i), 4'hF, 1'(i == 3), 1'b0, 1'b0, 1'b0), cyc);
      check_eq("sf_tvalid", 64'(m_if.tvalid), 64'(i == 3));
    end
    drain();
    // Over-long frame cuts through once full
    for (int i = 0; i < 20; i++) begin
      send(mk(32'(600 + i), 4'hF, 1'(i == 19), 1'b0, 1'b0, 1'b0), cyc);
      if (i < 15) check_eq("long_hold", 64'(m_if.tvalid), 64'd0);
      if (i == 15) begin
        check_eq("long_count16", 64'(count), 64'd16);
        check_eq("long_release", 64'(m_if.tvalid), 64'd1);
      end
    end
    drain();
`endif

    check_eq("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
